gcd_controller: RTL and testbench
=================================

# gcd_controller

Control FSM that drives the team's 16-bit subtract-and-compare GCD datapath (`GCD_datapath`). It accepts an operand pair over a valid/ready handshake and sequences the datapath's load, mux-select and input-select strobes from its `lt`/`gt`/`eq` status until the operands are equal. It then returns the result over a second valid/ready handshake, reads the A register through a tap, and handles zero operands without touching the datapath.

## Interface
- `WIDTH`, 16, operand, result and iteration-counter width; must match the datapath.
- `clk`  in  1  sole clock; all state changes on posedge.
- `rst`  in  1  synchronous, active-high reset; priority over every other input.
- `op_valid`  in  1  operand pair offered.
- `op_ready`  out  1  controller can accept; high only in IDLE.
- `op_a`, `op_b`  in  WIDTH  operands; sampled on the accepting edge.
- `lt`, `gt`, `eq`  in  1  datapath comparator status for A vs B (combinational from datapath registers).
- `res_in`  in  WIDTH  datapath A-register tap.
- `lda`, `ldb`  out  1  datapath A/B load enables.
- `sel1`, `sel2`  out  1  subtractor operand selects; 0 = A, 1 = B; subtractor computes X−Y.
- `selin`  out  1  bus select; 1 = `dp_data`, 0 = subtractor output.
- `dp_data`  out  WIDTH  value placed on the datapath input bus.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  WIDTH  GCD, registered.
- `iter_count`  out  WIDTH  number of subtraction cycles for the last/current operation; saturates at all-ones.
- `busy`  out  1  high in LOAD_A, LOAD_B and RUN.

## Operation
- States: IDLE, LOAD_A, LOAD_B, RUN, DONE.
- IDLE:
  - `op_ready`=1.
  - On `op_valid`, latch `op_a`/`op_b` into internal registers and clear `iter_count`.
  - If either operand is 0, set `result` to `op_a|op_b`, which gives gcd(0,x)=x and gcd(0,0)=0. Go to DONE with no datapath strobes.
  - Otherwise go to LOAD_A.
- LOAD_A: `selin`=1, `dp_data`=latched a, `lda`=1; go to LOAD_B.
- LOAD_B: `selin`=1, `dp_data`=latched b, `ldb`=1; go to RUN.
- RUN: outputs decode combinationally from the status inputs, one subtraction per cycle.
  - `gt`: `sel1`=0, `sel2`=1, `selin`=0, `lda`=1 (A ← A−B); increment `iter_count`.
  - `lt`: `sel1`=1, `sel2`=0, `selin`=0, `ldb`=1 (B ← B−A); increment `iter_count`.
  - `eq`: no loads; capture `res_in` into `result`; go to DONE.
  - The status inputs are one-hot by construction. If none is high, treat it as `eq`.
- DONE:
  - `out_valid`=1; `result` and `iter_count` stay stable.
  - On `out_ready`, go to IDLE.
  - `op_valid` is ignored in DONE.
- Default outputs, in any state or case not listed above: `lda`=`ldb`=`sel1`=`sel2`=`selin`=0, `dp_data`=0.
- `iter_count` saturates at 2^WIDTH−1. It holds its value after DONE until the next accept.
- Datapath registers have no reset. Their stale values are irrelevant because every operation reloads both registers before RUN.

## Timing
- Reset: on the first edge with `rst`=1, the state becomes IDLE and the outputs take these values:
  - `lda`=`ldb`=`sel1`=`sel2`=`selin`=0, `dp_data`=0.
  - `op_ready`=1 after that edge.
  - `out_valid`=0, `result`=0, `iter_count`=0, `busy`=0.
- Reset during any state, including mid-RUN or in DONE with the result unread, aborts the operation. The load strobes are 0 from the next cycle, and the pending result is lost.
- Accept occurs on edge T, when `op_valid` and `op_ready` are both high.
- Nonzero operands, N subtractions:
  - LOAD_A in cycle T+1, LOAD_B in T+2, RUN in T+3 … T+3+N.
  - `out_valid` rises in cycle T+4+N.
- Zero operand: `out_valid` rises in cycle T+1; `iter_count`=0.
- Back-to-back operations: `out_ready` high on DONE edge D gives `op_ready`=1 in D+1. The earliest next accept is edge D+1; there is no overlap.
- `out_valid` stays high and `result` stays stable until the handshake completes.

## Test plan
- 48, 18 accepted at T → RUN sequence gt, gt, lt, gt, eq; `result`=6, `iter_count`=4, `out_valid` in cycle T+8.
- 12, 12 → no strobes in RUN; `result`=12, `iter_count`=0, `out_valid` in cycle T+4.
- (0,5), (7,0), (0,0) → `result` 5, 7, 0 respectively; `out_valid` in cycle T+1; `lda`/`ldb` never asserted.
- 65535, 1 → 65534 consecutive `gt` cycles; `result`=1, `iter_count`=65534, `out_valid` in cycle T+65538.
- Hold `out_ready`=0 for 3 cycles in DONE and drive `op_valid`=1 with new operands → `result` stable, `op_ready`=0, new operands not accepted; completes on the 4th cycle.
- `rst` pulsed during RUN of 48, 18 → next cycle IDLE, `lda`=`ldb`=0, `out_valid`=0, `iter_count`=0. A following 9, 6 operation returns 3.

Source files
------------

// File: rtl/gcd_controller_if.sv
// Handshake and datapath-control bundle between the GCD controller and its
// environment (operand source, result sink and the subtract-and-compare datapath).
interface gcd_controller_if #(parameter int WIDTH = 16);
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             lt;
  logic             gt;
  logic             eq;
  logic [WIDTH-1:0] res_in;
  logic             lda;
  logic             ldb;
  logic             sel1;
  logic             sel2;
  logic             selin;
  logic [WIDTH-1:0] dp_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] iter_count;
  logic             busy;

  modport master (
    input  op_valid, op_a, op_b, lt, gt, eq, res_in, out_ready,
    output op_ready, lda, ldb, sel1, sel2, selin, dp_data,
           out_valid, result, iter_count, busy
  );

  modport slave (
    output op_valid, op_a, op_b, lt, gt, eq, res_in, out_ready,
    input  op_ready, lda, ldb, sel1, sel2, selin, dp_data,
           out_valid, result, iter_count, busy
  );
endinterface

// File: rtl/gcd_controller.sv
// Sequencing FSM for the subtract-and-compare GCD datapath: loads both operands,
// steps one subtraction per cycle until equal, then hands the result back.
module gcd_controller #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  gcd_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_RUN, S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_iter;

  logic w_gt;
  logic w_lt;
  logic w_step;
  logic w_zero_op;

  // Status is one-hot; anything that is not a clean gt/lt is treated as equal.
  assign w_gt      = bus.gt & ~bus.eq;
  assign w_lt      = bus.lt & ~bus.gt & ~bus.eq;
  assign w_step    = w_gt | w_lt;
  assign w_zero_op = (bus.op_a == '0) || (bus.op_b == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_iter   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.op_valid) begin
          r_a    <= bus.op_a;
          r_b    <= bus.op_b;
          r_iter <= '0;
          if (w_zero_op) begin
            r_result <= bus.op_a | bus.op_b;
            r_state  <= S_DONE;
          end else begin
            r_state  <= S_LOAD_A;
          end
        end
        S_LOAD_A: r_state <= S_LOAD_B;
        S_LOAD_B: r_state <= S_RUN;
        S_RUN: if (w_step) begin
          if (r_iter != '1) r_iter <= r_iter + WIDTH'(1);
        end else begin
          r_result <= bus.res_in;
          r_state  <= S_DONE;
        end
        S_DONE: if (bus.out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.lda     = 1'b0;
    bus.ldb     = 1'b0;
    bus.sel1    = 1'b0;
    bus.sel2    = 1'b0;
    bus.selin   = 1'b0;
    bus.dp_data = '0;
    case (r_state)
      S_LOAD_A: begin
        bus.selin   = 1'b1;
        bus.dp_data = r_a;
        bus.lda     = 1'b1;
      end
      S_LOAD_B: begin
        bus.selin   = 1'b1;
        bus.dp_data = r_b;
        bus.ldb     = 1'b1;
      end
      S_RUN: begin
        if (w_gt) begin
          bus.sel2 = 1'b1;
          bus.lda  = 1'b1;
        end else if (w_lt) begin
          bus.sel1 = 1'b1;
          bus.ldb  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.op_ready   = (r_state == S_IDLE);
  assign bus.out_valid  = (r_state == S_DONE);
  assign bus.busy       = (r_state == S_LOAD_A) || (r_state == S_LOAD_B) || (r_state == S_RUN);
  assign bus.result     = r_result;
  assign bus.iter_count = r_iter;

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: a behavioural datapath closes the loop, and every
// operation is scored against an arithmetic GCD/step-count reference.
module tb_gcd_controller;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcd_controller_if #(.WIDTH(W)) bus ();

  gcd_controller #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Datapath model: two unreset registers, mux-fed subtractor, comparator.
  logic [W-1:0] dA, dB, sub;
  assign sub        = (bus.sel1 ? dB : dA) - (bus.sel2 ? dB : dA);
  assign bus.lt     = dA < dB;
  assign bus.gt     = dA > dB;
  assign bus.eq     = dA == dB;
  assign bus.res_in = dA;
  always @(posedge clk) begin
    if (bus.lda) dA <= bus.selin ? bus.dp_data : sub;
    if (bus.ldb) dB <= bus.selin ? bus.dp_data : sub;
  end

  int n_lda = 0, n_ldb = 0;
  always @(negedge clk) begin
    if (bus.lda) n_lda = n_lda + 1;
    if (bus.ldb) n_ldb = n_ldb + 1;
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: repeated subtraction of smaller from larger until equal.
  function automatic void ref_gcd(input int a, input int b,
                                  output int g, output int ngt, output int nlt);
    ngt = 0; nlt = 0;
    if (a == 0 || b == 0) begin
      g = a | b;
      return;
    end
    while (a != b) begin
      if (a > b) begin a = a - b; ngt++; end
      else       begin b = b - a; nlt++; end
    end
    g = a;
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!bus.op_ready && t < 100) begin @(negedge clk); t++; end
    chk("op_ready_timeout", bus.op_ready, 1);
  endtask

  task automatic do_op(input int a, input int b, input int hold);
    int g, ngt, nlt, lat, lda0, ldb0, steps;
    logic zero;
    ref_gcd(a, b, g, ngt, nlt);
    zero  = (a == 0 || b == 0);
    steps = ngt + nlt;
    wait_ready();
    lda0 = n_lda; ldb0 = n_ldb;
    bus.op_a = W'(a); bus.op_b = W'(b); bus.op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 70000) begin @(negedge clk); lat++; end
    chk("latency", lat, zero ? 1 : 4 + steps);
    chk("result", bus.result, g);
    chk("iter_count", bus.iter_count, (steps > 65535) ? 65535 : steps);
    chk("lda_count", n_lda - lda0, zero ? 0 : 1 + ngt);
    chk("ldb_count", n_ldb - ldb0, zero ? 0 : 1 + nlt);
    chk("busy_done", bus.busy, 0);
    for (int i = 0; i < hold; i++) begin
      bus.op_valid = 1'b1;
      bus.op_a = W'($urandom_range(1, 200));
      bus.op_b = W'($urandom_range(1, 200));
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_result", bus.result, g);
      chk("hold_op_ready", bus.op_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.op_valid  = 1'b0;
    chk("idle_op_ready", bus.op_ready, 1);
    chk("idle_out_valid", bus.out_valid, 0);
    chk("iter_hold", bus.iter_count, (steps > 65535) ? 65535 : steps);
  endtask

  initial begin
    bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_op_ready", bus.op_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_iter", bus.iter_count, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_strobes", {bus.lda, bus.ldb, bus.sel1, bus.sel2, bus.selin}, 0);
    chk("rst_dp_data", bus.dp_data, 0);
    rst = 1'b0;
    @(negedge clk);

    do_op(48, 18, 0);
    do_op(12, 12, 0);
    do_op(0, 5, 0);
    do_op(7, 0, 0);
    do_op(0, 0, 0);
    do_op(65535, 1, 0);
    do_op(48, 18, 3);

    // Reset in the middle of RUN.
    wait_ready();
    bus.op_a = 16'd48; bus.op_b = 16'd18; bus.op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrun_busy", bus.busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_op_ready", bus.op_ready, 1);
    chk("abort_lda_ldb", {bus.lda, bus.ldb}, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_iter", bus.iter_count, 0);
    chk("abort_busy", bus.busy, 0);
    rst = 1'b0;
    @(negedge clk);
    do_op(9, 6, 0);

    for (int k = 0; k < 24; k++) begin
      int a, b;
      a = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      do_op(a, b, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
